// File: rtl/decoder_sweep_if.sv
// Command/status bundle for decoder_sweep. The master drives the select and
// the commands; the slave returns the decoded strobe and the sweep status.
interface decoder_sweep_if #(
  parameter int IN_WIDTH = 3
);
  localparam int OUT_WIDTH = 2 ** IN_WIDTH;

  logic                 enable_i;
  logic [IN_WIDTH-1:0]  in_i;
  logic                 load_i;
  logic                 sweep_start_i;
  logic                 sweep_stop_i;
  logic [OUT_WIDTH-1:0] out_o;
  logic [IN_WIDTH-1:0]  index_o;
  logic                 busy_o;
  logic                 wrap_o;

  modport master (
    output enable_i, in_i, load_i, sweep_start_i, sweep_stop_i,
    input  out_o, index_o, busy_o, wrap_o
  );

  modport slave (
    input  enable_i, in_i, load_i, sweep_start_i, sweep_stop_i,
    output out_o, index_o, busy_o, wrap_o
  );
endinterface

// File: rtl/decoder_sweep.sv
// Registered one-hot decoder with HOLD and auto-incrementing SWEEP modes.
// state | meaning
// IDLE  | output inactive, index retained
// HOLD  | output decodes a latched index
// SWEEP | index advances every STEP_DIV cycles, wrapping to 0
module decoder_sweep #(
  parameter int IN_WIDTH   = 3,
  parameter int STEP_DIV   = 1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic            clk,
  input logic            rst,
  decoder_sweep_if.slave bus
);
  localparam int OUT_WIDTH = 2 ** IN_WIDTH;
  localparam int DIV_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [OUT_WIDTH-1:0] INACTIVE = ACTIVE_LOW ? {OUT_WIDTH{1'b1}} : '0;
  localparam logic [IN_WIDTH-1:0]  IDX_MAX  = {IN_WIDTH{1'b1}};
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SWEEP} state_t;

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  index_q, index_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 wrap_q, wrap_d;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    div_d   = div_q;
    wrap_d  = 1'b0;
    if (bus.enable_i) begin
      if (bus.sweep_stop_i) begin
        state_d = S_IDLE;
      end else if (bus.sweep_start_i) begin
        index_d = bus.in_i;
        div_d   = '0;
        state_d = S_SWEEP;
      end else if (bus.load_i) begin
        index_d = bus.in_i;
        div_d   = '0;
        if (state_q == S_IDLE) state_d = S_HOLD;
      end else if (state_q == S_SWEEP) begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          index_d = index_q + 1'b1;
          wrap_d  = (index_q == IDX_MAX);
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    end
    busy_d = (state_d == S_SWEEP);
    // Disabled cycles blank the strobe but leave the sweep position intact.
    if (bus.enable_i && state_d != S_IDLE)
      out_d = ACTIVE_LOW ? ~(OUT_WIDTH'(1) << index_d) : (OUT_WIDTH'(1) << index_d);
    else
      out_d = INACTIVE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      index_q <= '0;
      div_q   <= '0;
      out_q   <= INACTIVE;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      div_q   <= div_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.out_o   = out_q;
  assign bus.index_o = index_q;
  assign bus.busy_o  = busy_q;
  assign bus.wrap_o  = wrap_q;
endmodule

// File: tb/tb_decoder_sweep.sv
// Directed bench: an active-high STEP_DIV=2 decoder and an active-low
// STEP_DIV=1 decoder driven by the same commands.
module tb_decoder_sweep;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decoder_sweep_if #(.IN_WIDTH(3)) b1 ();
  decoder_sweep_if #(.IN_WIDTH(3)) b2 ();

  assign b2.enable_i      = b1.enable_i;
  assign b2.in_i          = b1.in_i;
  assign b2.load_i        = b1.load_i;
  assign b2.sweep_start_i = b1.sweep_start_i;
  assign b2.sweep_stop_i  = b1.sweep_stop_i;

  decoder_sweep #(.IN_WIDTH(3), .STEP_DIV(2), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(b1.slave));
  decoder_sweep #(.IN_WIDTH(3), .STEP_DIV(1), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .bus(b2.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [7:0] o, input logic [2:0] idx,
                          input logic busy, input logic wrap);
    chk({tag, ".out"},   32'(b1.out_o),   32'(o));
    chk({tag, ".index"}, 32'(b1.index_o), 32'(idx));
    chk({tag, ".busy"},  32'(b1.busy_o),  32'(busy));
    chk({tag, ".wrap"},  32'(b1.wrap_o),  32'(wrap));
  endtask

  logic [2:0] sw_idx [10] = '{3'd6, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3};

  initial begin
    b1.enable_i = 1'b1;
    b1.in_i = '0;
    b1.load_i = 1'b0;
    b1.sweep_start_i = 1'b0;
    b1.sweep_stop_i = 1'b0;
    #23 rst = 1'b0;

    // Reset and idle
    for (int i = 0; i < 10; i++) begin
      step();
      chk_main("idle", 8'h00, 3'd0, 1'b0, 1'b0);
    end
    chk("idle.out_lo", 32'(b2.out_o), 32'hFF);

    // Direct decode via load
    for (int i = 0; i < 8; i++) begin
      b1.in_i = 3'(i);
      b1.load_i = 1'b1;
      step();
      chk_main("load", 8'(1 << i), 3'(i), 1'b0, 1'b0);
      chk("load.out_lo", 32'(b2.out_o), 32'(8'(~(8'd1 << i))));
    end
    b1.load_i = 1'b0;
    b1.in_i = 3'd2;
    step();
    chk_main("hold", 8'h80, 3'd7, 1'b0, 1'b0);

    // Sweep from 6 with STEP_DIV=2; the active-low copy steps every cycle
    b1.in_i = 3'd6;
    b1.sweep_start_i = 1'b1;
    step();
    b1.sweep_start_i = 1'b0;
    chk_main("start", 8'h40, 3'd6, 1'b1, 1'b0);
    chk("start.out_lo", 32'(b2.out_o), 32'hBF);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_main("sweep", 8'(1 << sw_idx[i]), sw_idx[i], 1'b1, (i == 3));
      if (i == 0) chk("sweep.idx_lo1", 32'(b2.index_o), 32'd7);
      if (i == 1) begin
        chk("sweep.idx_lo2", 32'(b2.index_o), 32'd0);
        chk("sweep.wrap_lo", 32'(b2.wrap_o), 32'd1);
      end
    end

    // Enable gating at index 3 (divider at 0)
    b1.enable_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_main("gate", 8'h00, 3'd3, 1'b1, 1'b0);
    end
    chk("gate.out_lo", 32'(b2.out_o), 32'hFF);
    b1.enable_i = 1'b1;
    step();
    chk_main("resume0", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    chk_main("resume1", 8'h10, 3'd4, 1'b1, 1'b0);

    // Simultaneous commands
    b1.sweep_stop_i = 1'b1;
    b1.sweep_start_i = 1'b1;
    b1.load_i = 1'b1;
    b1.in_i = 3'd1;
    step();
    chk_main("all3", 8'h00, 3'd4, 1'b0, 1'b0);
    chk("all3.out_lo", 32'(b2.out_o), 32'hFF);
    b1.sweep_stop_i = 1'b0;
    b1.in_i = 3'd5;
    step();
    b1.sweep_start_i = 1'b0;
    b1.load_i = 1'b0;
    chk_main("start_load", 8'h20, 3'd5, 1'b1, 1'b0);

    // Advance to index 7, then reset asynchronously between edges
    step();
    chk_main("to7a", 8'h20, 3'd5, 1'b1, 1'b0);
    step();
    step();
    step();
    chk_main("to7b", 8'h80, 3'd7, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_main("arst", 8'h00, 3'd0, 1'b0, 1'b0);
    chk("arst.out_lo", 32'(b2.out_o), 32'hFF);
    step();
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_main("post_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
